mem_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register.
- Decodes the registered EX/MEM fields and runs load/store accesses to data memory over a req/ready handshake, stalling upstream while an access is outstanding.
- Resolves JEQ branches and drives the flush/redirect back to fetch.
- Holds the MEM/WB pipeline register that feeds writeback.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/mem_wb_reg.sv | 22 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bit indices, MEM/WB payload and MEM-stage FSM states.
package cpu_pkg;

  localparam int unsigned CTL_W        = 5;
  localparam int unsigned CTL_REGWRITE = 4;
  localparam int unsigned CTL_MEMTOREG = 3;
  localparam int unsigned CTL_MEMREAD  = 2;
  localparam int unsigned CTL_MEMWRITE = 1;
  localparam int unsigned CTL_BRANCH   = 0;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memStateT;

  typedef struct packed {
    logic              regWrite;
    logic              memToReg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] readData;
    logic [REG_W-1:0]  reg1;
  } memWbT;

  localparam int unsigned MEMWB_W = $bits(memWbT);

  localparam memWbT MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads a bubble instead of WbIn whenever Bubble is high.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Bubble,
  input  logic [MEMWB_W-1:0] WbIn,
  output logic [MEMWB_W-1:0] WbOut
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WbOut <= MEMWB_BUBBLE;
    end else if (Bubble) begin
      WbOut <= MEMWB_BUBBLE;
    end else begin
      WbOut <= WbIn;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake with stall/timeout, JEQ resolution, MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ControlsIn,
  input  logic [15:0] ResultIn,
  input  logic        ZeroIn,
  input  logic [15:0] DataIn,
  input  logic [15:0] MemAddrIn,
  input  logic [15:0] JEQAddrIn,
  input  logic [2:0]  Reg1In,
  output logic        MemReq,
  output logic        MemWe,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic        MemReady,
  input  logic [15:0] MemRData,
  output logic        Stall,
  output logic        BranchTaken,
  output logic [15:0] BranchTarget,
  output logic        MemErr,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [15:0] ResultOut,
  output logic [15:0] ReadDataOut,
  output logic [2:0]  Reg1Out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  memStateT         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             memReq, stall, done, timeoutHit, errSet;
  memWbT            wbNext, wbQ;

  wire memRead  = ControlsIn[CTL_MEMREAD];
  wire memWrite = ControlsIn[CTL_MEMWRITE];
  wire branch   = ControlsIn[CTL_BRANCH];
  wire memOp    = memRead | memWrite;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      MemErr <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (errSet) begin
        MemErr <= 1'b1;
      end
    end
  end

  // Next state, handshake and stall; Reset overrides any in-flight request.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    memReq     = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (memOp) begin
          memReq = 1'b1;
          if (MemReady) begin
            done = 1'b1;
          end else begin
            stall     = 1'b1;
            stateNext = BUSY;
            cntNext   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        memReq = 1'b1;
        if (MemReady) begin
          done      = 1'b1;
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cnt < CNT_MAX) begin
          stall   = 1'b1;
          cntNext = cnt + CNT_W'(1);
        end else begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
          cntNext    = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
    if (Reset) begin
      memReq     = 1'b0;
      stall      = 1'b0;
      done       = 1'b0;
      timeoutHit = 1'b0;
    end
  end

  assign errSet = timeoutHit | (memReq & memRead & memWrite) | (branch & memOp);

  assign MemReq   = memReq;
  assign Stall    = stall;
  assign MemWe    = memReq & memWrite;
  assign MemAddr  = memReq ? MemAddrIn : '0;
  assign MemWData = memReq ? DataIn : '0;

  assign BranchTaken  = branch & ZeroIn & ~memOp;
  assign BranchTarget = JEQAddrIn;

  // Load data only on a completed read; illegal read+write executes as a write.
  always_comb begin
    wbNext          = MEMWB_BUBBLE;
    wbNext.regWrite = ControlsIn[CTL_REGWRITE];
    wbNext.memToReg = ControlsIn[CTL_MEMTOREG];
    wbNext.result   = ResultIn;
    wbNext.reg1     = Reg1In;
    wbNext.readData = (done && !memWrite) ? MemRData : '0;
  end

  mem_wb_reg uMemWb (
    .Clk   (Clk),
    .Reset (Reset),
    .Bubble(stall | timeoutHit),
    .WbIn  (wbNext),
    .WbOut (wbQ)
  );

  assign RegWriteOut = wbQ.regWrite;
  assign MemToRegOut = wbQ.memToReg;
  assign ResultOut   = wbQ.result;
  assign ReadDataOut = wbQ.readData;
  assign Reg1Out     = wbQ.reg1;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table plus hand-written wait, reset, error and timeout sequences.
module tb_mem_stage;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ControlsIn;
  logic [15:0] ResultIn;
  logic        ZeroIn;
  logic [15:0] DataIn;
  logic [15:0] MemAddrIn;
  logic [15:0] JEQAddrIn;
  logic [2:0]  Reg1In;
  logic        MemReq;
  logic        MemWe;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemReady;
  logic [15:0] MemRData;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        MemErr;
  logic        RegWriteOut;
  logic        MemToRegOut;
  logic [15:0] ResultOut;
  logic [15:0] ReadDataOut;
  logic [2:0]  Reg1Out;

  mem_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .ControlsIn(ControlsIn), .ResultIn(ResultIn),
    .ZeroIn(ZeroIn), .DataIn(DataIn), .MemAddrIn(MemAddrIn), .JEQAddrIn(JEQAddrIn),
    .Reg1In(Reg1In), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemReady(MemReady), .MemRData(MemRData), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .MemErr(MemErr),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .ResultOut(ResultOut),
    .ReadDataOut(ReadDataOut), .Reg1Out(Reg1Out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] result;
    logic        zero;
    logic [15:0] data;
    logic [15:0] addr;
    logic [15:0] jeq;
    logic [2:0]  reg1;
    logic        ready;
    logic [15:0] rdata;
    logic        reset;
    logic        eReq;
    logic        eWe;
    logic        eStall;
    logic        eBr;
    logic        eRw;
    logic        eMtr;
    logic [15:0] eRes;
    logic [15:0] eRd;
    logic [2:0]  eReg;
  } vecT;

  int unsigned nApplied = 0;
  int unsigned nMiss    = 0;
  logic [36:0] sb[$];

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then the MEM/WB result after the edge.
  task automatic applyVec(input vecT v, input string tag);
    logic [36:0] exp;
    ControlsIn = v.ctl;
    ResultIn   = v.result;
    ZeroIn     = v.zero;
    DataIn     = v.data;
    MemAddrIn  = v.addr;
    JEQAddrIn  = v.jeq;
    Reg1In     = v.reg1;
    MemReady   = v.ready;
    MemRData   = v.rdata;
    Reset      = v.reset;
    #2;
    check({tag, " MemReq"}, 37'(MemReq), 37'(v.eReq));
    if (v.eReq) begin
      check({tag, " MemWe"}, 37'(MemWe), 37'(v.eWe));
      check({tag, " MemAddr"}, 37'(MemAddr), 37'(v.addr));
      if (v.eWe) check({tag, " MemWData"}, 37'(MemWData), 37'(v.data));
    end
    check({tag, " Stall"}, 37'(Stall), 37'(v.eStall));
    check({tag, " BranchTaken"}, 37'(BranchTaken), 37'(v.eBr));
    if (v.eBr) check({tag, " BranchTarget"}, 37'(BranchTarget), 37'(v.jeq));
    sb.push_back({v.eRw, v.eMtr, v.eRes, v.eRd, v.eReg});
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      nApplied++;
      nMiss++;
      $display("FAIL %s memwb: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, " memwb"}, {RegWriteOut, MemToRegOut, ResultOut, ReadDataOut, Reg1Out}, exp);
    end
  endtask

  task automatic checkErr(input string tag, input logic exp);
    check({tag, " MemErr"}, 37'(MemErr), 37'(exp));
  endtask

  vecT tbl[8];
  vecT ld, rst, nop;

  initial begin
    // ctl, result, zero, data, addr, jeq, reg1, ready, rdata, reset | eReq, eWe, eStall, eBr | eRw, eMtr, eRes, eRd, eReg
    tbl[0] = '{5'b10000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd3, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd3};
    tbl[1] = '{5'b10000, 16'h5555, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd7, 1'b1, 16'hDEAD, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0000, 3'd7};
    tbl[2] = '{5'b00010, 16'h0100, 1'b0, 16'h00FF, 16'h0100, 16'h0000, 3'd2, 1'b1, 16'h1111, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 3'd2};
    tbl[3] = '{5'b11100, 16'h0040, 1'b0, 16'h0000, 16'h0040, 16'h0000, 3'd5, 1'b1, 16'hCAFE, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hCAFE, 3'd5};
    tbl[4] = '{5'b00001, 16'h0011, 1'b1, 16'h0000, 16'h0000, 16'h0020, 3'd1, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd1};
    tbl[5] = '{5'b00001, 16'h0011, 1'b0, 16'h0000, 16'h0000, 16'h0020, 3'd1, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd1};
    tbl[6] = '{5'b11000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd7, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 3'd7};
    tbl[7] = '{5'b10000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0030, 3'd4, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd4};

    ld  = '{5'b11100, 16'h0040, 1'b0, 16'h0000, 16'h0040, 16'h0000, 3'd6, 1'b0, 16'h0000, 1'b0,
            1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0};
    rst = '{5'b00000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0};
    nop = '{5'b00000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0};

    applyVec(rst, "reset");
    checkErr("reset", 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyVec(tbl[i], $sformatf("tbl%0d", i));
    end
    checkErr("tbl", 1'b0);

    // Load with two wait cycles, then a back-to-back zero-wait store.
    applyVec(ld, "ldw0");
    applyVec(ld, "ldw1");
    applyVec('{5'b11100, 16'h0040, 1'b0, 16'h0000, 16'h0040, 16'h0000, 3'd6, 1'b1, 16'hBEEF, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 3'd6}, "ldw2");
    applyVec('{5'b00010, 16'h0200, 1'b0, 16'h00FF, 16'h0200, 16'h0000, 3'd0, 1'b1, 16'h0000, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 3'd0}, "b2bst");
    checkErr("ldw", 1'b0);

    // Illegal read+write executes as a write and flags an error.
    applyVec('{5'b00110, 16'h0300, 1'b0, 16'hA5A5, 16'h0300, 16'h0000, 3'd0, 1'b1, 16'h7777, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 3'd0}, "illegal");
    checkErr("illegal", 1'b1);

    // Reset while BUSY drops the request and clears the sticky error.
    applyVec(ld, "rstbusy0");
    rst.ctl  = 5'b11100;
    rst.addr = 16'h0040;
    applyVec(rst, "rstbusy1");
    checkErr("rstbusy", 1'b0);
    applyVec(nop, "rstidle");

    // Branch together with a memory op: no redirect, error set, load still completes.
    applyVec('{5'b00101, 16'h0400, 1'b1, 16'h0000, 16'h0400, 16'h0050, 3'd0, 1'b1, 16'h9999, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h9999, 3'd0}, "brmem");
    checkErr("brmem", 1'b1);
    rst.ctl  = 5'b00000;
    rst.addr = 16'h0000;
    applyVec(rst, "rst2");
    checkErr("rst2", 1'b0);

    // Timeout: four stalled cycles, released on the fifth with a bubble.
    for (int i = 0; i < 4; i++) begin
      applyVec(ld, $sformatf("tmo%0d", i));
    end
    ld.eStall = 1'b0;
    applyVec(ld, "tmo4");
    checkErr("tmo", 1'b1);
    applyVec('{5'b10000, 16'h0ABC, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd2, 1'b0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0ABC, 16'h0000, 3'd2}, "posttmo");
    checkErr("sticky", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
